axis_frame_rr_sched: RTL

- Frame-atomic round-robin scheduler that shares one AXI-Stream datapath (e.g. an async FIFO adapter input) between S_COUNT requesters.
- Grants one source per frame and tags each beat's tid with the source index.
- A stall watchdog terminates a stalled frame with a bad-frame marker so a hung source cannot hold the shared FIFO.
- Sits in the producer clock domain, directly upstream of the FIFO adapter.

---
 rtl/axis_frame_rr_sched.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/axis_frame_rr_sched.sv
// Frame-atomic round-robin scheduler for AXI-Stream sources feeding one shared datapath.
// Output is a registered stage with a one-entry skid; a stall watchdog force-terminates hung frames.
module axis_frame_rr_sched #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 1,
  parameter int TIMEOUT    = 256,
  localparam int GW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT-1:0]            s_enable,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic [GW-1:0]                 grant_index,
  output logic                          busy,
  output logic                          timeout_event
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] STALL_MAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // Handshake: a beat moves on any interface when tvalid and tready are both high
  // at the rising edge of clk; tvalid never waits on tready.
  typedef enum logic [1:0] {IDLE, XFER, DROP} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [CW-1:0]   stall_q, stall_d;
  logic            tev_q, tev_d;

  logic [DATA_WIDTH-1:0] out_data_q, sk_data_q;
  logic [USER_WIDTH-1:0] out_user_q, sk_user_q;
  logic [GW-1:0]         out_id_q, sk_id_q;
  logic                  out_valid_q, sk_valid_q;
  logic                  out_last_q, sk_last_q;

  logic                  in_ready;
  logic                  out_free;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [USER_WIDTH-1:0] sel_user;

  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  push_last;
  logic [USER_WIDTH-1:0] push_user;

  logic [S_COUNT-1:0]    req;
  logic                  found;
  logic [GW-1:0]         pick_idx;
  int                    rr_idx;

  assign in_ready  = !sk_valid_q;
  assign out_free  = !out_valid_q || m_axis_tready;
  assign sel_valid = s_axis_tvalid[grant_q];
  assign sel_last  = s_axis_tlast[grant_q];
  assign sel_data  = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_user  = s_axis_tuser[int'(grant_q)*USER_WIDTH +: USER_WIDTH];
  assign req       = s_axis_tvalid & s_enable;

  // Rotating priority: the source just after the previous grant is checked first.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    rr_idx   = 0;
    for (int k = 1; k <= S_COUNT; k++) begin
      rr_idx = (int'(last_q) + k) % S_COUNT;
      if (!found && req[rr_idx]) begin
        found    = 1'b1;
        pick_idx = GW'(rr_idx);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    stall_d       = stall_q;
    tev_d         = 1'b0;
    push          = 1'b0;
    push_data     = sel_data;
    push_last     = sel_last;
    push_user     = sel_user;
    s_axis_tready = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick_idx;
          stall_d = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        s_axis_tready[grant_q] = in_ready;
        if (in_ready) begin
          if (sel_valid) begin
            push    = 1'b1;
            stall_d = '0;
            if (sel_last) begin
              last_d  = grant_q;
              state_d = IDLE;
            end
          end else if (TIMEOUT > 0) begin
            // Stall limit reached: close the frame downstream with a bad-frame marker.
            if (stall_q == STALL_MAX) begin
              push      = 1'b1;
              push_data = '0;
              push_last = 1'b1;
              push_user = '1;
              tev_d     = 1'b1;
              state_d   = DROP;
            end else begin
              stall_d = stall_q + CW'(1);
            end
          end
        end
      end
      DROP: begin
        s_axis_tready[grant_q] = 1'b1;
        if (sel_valid && sel_last) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(S_COUNT - 1);
      stall_q <= '0;
      tev_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      stall_q <= stall_d;
      tev_q   <= tev_d;
    end
  end

  // Output register refills from the skid first; new beats only enter while the skid is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_user_q  <= '0;
      out_id_q    <= '0;
      sk_valid_q  <= 1'b0;
      sk_data_q   <= '0;
      sk_last_q   <= 1'b0;
      sk_user_q   <= '0;
      sk_id_q     <= '0;
    end else if (out_free) begin
      if (sk_valid_q) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sk_data_q;
        out_last_q  <= sk_last_q;
        out_user_q  <= sk_user_q;
        out_id_q    <= sk_id_q;
        sk_valid_q  <= 1'b0;
      end else if (push) begin
        out_valid_q <= 1'b1;
        out_data_q  <= push_data;
        out_last_q  <= push_last;
        out_user_q  <= push_user;
        out_id_q    <= grant_q;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (push) begin
      sk_valid_q <= 1'b1;
      sk_data_q  <= push_data;
      sk_last_q  <= push_last;
      sk_user_q  <= push_user;
      sk_id_q    <= grant_q;
    end
  end

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tuser  = out_user_q;
  assign m_axis_tid    = ID_WIDTH'(out_id_q);
  assign grant_index   = grant_q;
  assign busy          = (state_q != IDLE);
  assign timeout_event = tev_q;

endmodule
